// File: rtl/vault_arbiter_if.sv
// vault_arbiter_if: one client's request/response bundle.
// master = requesting client, slave = arbiter side.
interface vault_arbiter_if #(
   parameter int DW = 8,
   parameter int AW = 2
);
   logic          valid;
   logic          we;
   logic [AW-1:0] addr;
   logic [DW-1:0] wdata;
   logic          ready;
   logic          rsp_valid;
   logic [DW-1:0] rsp_rdata;

   modport master (
      output valid, we, addr, wdata,
      input  ready, rsp_valid, rsp_rdata
   );

   modport slave (
      input  valid, we, addr, wdata,
      output ready, rsp_valid, rsp_rdata
   );
endinterface

// File: rtl/vault_arbiter.sv
// vault_arbiter: two-client round-robin sequencer that owns
// the BitVault addr/we/data_in pins and serialises accesses.
module vault_arbiter #(
   parameter int DW = 8,
   parameter int AW = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   vault_arbiter_if.slave p0,
   vault_arbiter_if.slave p1,
   output logic [AW-1:0] vault_addr,
   output logic          vault_we,
   output logic [DW-1:0] vault_wdata,
   input  logic [DW-1:0] vault_rdata,
   output logic          busy,
   output logic          grant_id
);

   typedef enum logic [2:0] {
      IDLE, WR, RD, RD_CAP, RESP
   } state_t;

   state_t        state;
   logic          last_grant;
   logic          win;
   logic          any_req;
   logic          w_we;
   logic [AW-1:0] w_addr;
   logic [DW-1:0] w_wdata;
   logic          rv0, rv1;
   logic [DW-1:0] rd0, rd1;

   // Pick the winner: sole requester, or the one not served last on a tie.
   always_comb begin
      any_req = p0.valid | p1.valid;
      win     = 1'b0;
      if (p0.valid && p1.valid)
         win = ~last_grant;
      else if (p1.valid)
         win = 1'b1;
      w_we    = win ? p1.we    : p0.we;
      w_addr  = win ? p1.addr  : p0.addr;
      w_wdata = win ? p1.wdata : p0.wdata;
   end

   assign p0.ready     = (state == IDLE) && any_req && !win;
   assign p1.ready     = (state == IDLE) && any_req && win;
   assign p0.rsp_valid = rv0;
   assign p1.rsp_valid = rv1;
   assign p0.rsp_rdata = rd0;
   assign p1.rsp_rdata = rd1;

   // Transaction sequencer; vault pins and responses are registered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         last_grant  <= 1'b1;
         grant_id    <= 1'b0;
         busy        <= 1'b0;
         vault_addr  <= '0;
         vault_we    <= 1'b0;
         vault_wdata <= '0;
         rv0         <= 1'b0;
         rv1         <= 1'b0;
         rd0         <= '0;
         rd1         <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (any_req) begin
                  grant_id   <= win;
                  last_grant <= win;
                  vault_addr <= w_addr;
                  busy       <= 1'b1;
                  if (w_we) begin
                     vault_wdata <= w_wdata;
                     vault_we    <= 1'b1;
                     state       <= WR;
                  end else begin
                     state <= RD;
                  end
               end
            end
            WR: begin
               vault_we <= 1'b0;
               if (grant_id) begin
                  rv1 <= 1'b1;
                  rd1 <= '0;
               end else begin
                  rv0 <= 1'b1;
                  rd0 <= '0;
               end
               state <= RESP;
            end
            RD: state <= RD_CAP;
            RD_CAP: begin
               if (grant_id) begin
                  rv1 <= 1'b1;
                  rd1 <= vault_rdata;
               end else begin
                  rv0 <= 1'b1;
                  rd0 <= vault_rdata;
               end
               state <= RESP;
            end
            RESP: begin
               rv0   <= 1'b0;
               rv1   <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
